// File: rtl/smi_rx_arbiter.sv
// ============================================================================
// Module   : smi_rx_arbiter
// Purpose  : Round-robin burst arbiter between the 0.9 GHz and 2.4 GHz RX
//            FIFOs, serialising each 32-bit word MSB-first onto a byte stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module smi_rx_arbiter #(
    parameter int BURST_MAX = 15
) (
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [3:0]  i_burst_len,
    input  logic        i_fifo_09_empty,
    input  logic [31:0] i_fifo_09_pulled_data,
    output logic        o_fifo_09_pull,
    input  logic        i_fifo_24_empty,
    input  logic [31:0] i_fifo_24_pulled_data,
    output logic        o_fifo_24_pull,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_channel,
    output logic        o_sof,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PULL = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam logic [3:0] c_burst_max = 4'(BURST_MAX);

    state_t      state_q, state_d;
    logic [3:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shift_q, shift_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        chan_q, chan_d;
    logic        pull09_q, pull09_d;
    logic        pull24_q, pull24_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        busy_q, busy_d;

    logic        w_grant;
    logic [3:0]  w_len;
    logic        w_sel_empty;
    logic [31:0] w_sel_data;
    logic        w_accept;

    assign w_len       = (i_burst_len > c_burst_max) ? c_burst_max : i_burst_len;
    assign w_sel_empty = chan_q ? i_fifo_24_empty : i_fifo_09_empty;
    assign w_sel_data  = chan_q ? i_fifo_24_pulled_data : i_fifo_09_pulled_data;
    assign w_accept    = valid_q & i_byte_ready;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= 4'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
            first_q    <= 1'b0;
            last_q     <= 1'b1;
            chan_q     <= 1'b0;
            pull09_q   <= 1'b0;
            pull24_q   <= 1'b0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            first_q    <= first_d;
            last_q     <= last_d;
            chan_q     <= chan_d;
            pull09_q   <= pull09_d;
            pull24_q   <= pull24_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        first_d    = first_q;
        last_d     = last_q;
        chan_d     = chan_q;
        pull09_d   = 1'b0;
        pull24_d   = 1'b0;
        valid_d    = valid_q;
        sof_d      = sof_q;
        busy_d     = busy_q;
        w_grant    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && (!i_fifo_09_empty || !i_fifo_24_empty)) begin
                    // Both pending: alternate away from the last-served source
                    if (!i_fifo_09_empty && !i_fifo_24_empty) begin
                        w_grant = ~last_q;
                    end else begin
                        w_grant = i_fifo_09_empty;
                    end
                    chan_d     = w_grant;
                    word_cnt_d = w_len;
                    first_d    = 1'b1;
                    pull09_d   = ~w_grant;
                    pull24_d   = w_grant;
                    busy_d     = 1'b1;
                    state_d    = ST_PULL;
                end
            end
            ST_PULL: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d    = w_sel_data;
                byte_idx_d = 2'd0;
                valid_d    = 1'b1;
                sof_d      = first_q;
                first_d    = 1'b0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (w_accept) begin
                    sof_d   = 1'b0;
                    shift_d = {shift_q[23:0], 8'h00};
                    if (byte_idx_q == 2'd3) begin
                        valid_d = 1'b0;
                        // Continuation is decided only at the word boundary
                        if ((word_cnt_q != 4'd0) && !w_sel_empty && i_enable) begin
                            word_cnt_d = word_cnt_q - 4'd1;
                            pull09_d   = ~chan_q;
                            pull24_d   = chan_q;
                            state_d    = ST_PULL;
                        end else begin
                            busy_d  = 1'b0;
                            last_d  = chan_q;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_fifo_09_pull = pull09_q;
    assign o_fifo_24_pull = pull24_q;
    assign o_byte         = shift_q[31:24];
    assign o_byte_valid   = valid_q;
    assign o_channel      = chan_q;
    assign o_sof          = sof_q;
    assign o_busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_smi_rx_arbiter.sv
// ============================================================================
// Module   : tb_smi_rx_arbiter
// Purpose  : Directed scoreboard bench for smi_rx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_smi_rx_arbiter;

    typedef struct packed {
        logic       ch;
        logic [7:0] b;
        logic       sof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        ready = 1'b1;
    logic [3:0]  blen = 4'd0;
    logic        e09 = 1'b1;
    logic        e24 = 1'b1;
    logic [31:0] d09 = 32'd0;
    logic [31:0] d24 = 32'd0;
    logic        pull09, pull24, valid, chan, sof, busy;
    logic [7:0]  obyte;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_bytes = 0, n_sof = 0, n_pull09 = 0, n_pull24 = 0;
    int sof_cyc = 0, last_cyc = 0, bad_pull = 0;

    logic [31:0] q09[$];
    logic [31:0] q24[$];
    exp_t        exp_q[$];
    exp_t        e_mon;
    logic        hold_pend = 1'b0;
    logic [7:0]  held_byte = 8'd0;

    smi_rx_arbiter #(.BURST_MAX(15)) dut (
        .i_sys_clk            (clk),
        .i_rst                (rst),
        .i_enable             (enable),
        .i_burst_len          (blen),
        .i_fifo_09_empty      (e09),
        .i_fifo_09_pulled_data(d09),
        .o_fifo_09_pull       (pull09),
        .i_fifo_24_empty      (e24),
        .i_fifo_24_pulled_data(d24),
        .o_fifo_24_pull       (pull24),
        .o_byte               (obyte),
        .o_byte_valid         (valid),
        .i_byte_ready         (ready),
        .o_channel            (chan),
        .o_sof                (sof),
        .o_busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // FIFO models: word appears on pulled_data the cycle after the pull
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pull09) begin
            if (q09.size() > 0) d09 <= q09.pop_front();
            else bad_pull <= bad_pull + 1;
        end
        if (pull24) begin
            if (q24.size() > 0) d24 <= q24.pop_front();
            else bad_pull <= bad_pull + 1;
        end
    end

    always @(negedge clk) begin
        e09 = (q09.size() == 0);
        e24 = (q24.size() == 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(valid), 1);
                check("hold_byte", 32'(obyte), 32'(held_byte));
            end
            hold_pend = valid && !ready;
            held_byte = obyte;
            if (valid && ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_byte observed=%h expected=none", obyte);
                end
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    check("sb_byte", 32'(obyte), 32'(e_mon.b));
                    check("sb_chan", 32'(chan), 32'(e_mon.ch));
                    check("sb_sof", 32'(sof), 32'(e_mon.sof));
                end
                n_bytes++;
                if (sof) begin
                    n_sof++;
                    sof_cyc = cyc;
                end
                last_cyc = cyc;
            end
            if (pull09) n_pull09++;
            if (pull24) n_pull24++;
            if (pull09 || pull24) check("pull_exclusive", 32'(pull09 & pull24), 0);
        end
    end

    task automatic fifo_put(input logic ch, input logic [31:0] w);
        if (ch) q24.push_back(w);
        else    q09.push_back(w);
    endtask

    task automatic expect_word(input logic ch, input logic [31:0] w, input logic first, input int nb);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            e.ch  = ch;
            e.b   = w[31-8*i -: 8];
            e.sof = first && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_counts();
        n_bytes  = 0;
        n_sof    = 0;
        n_pull09 = 0;
        n_pull24 = 0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check({tag, "_drain"}, 32'(done), 1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (valid) done = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(done), 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pull09"}, 32'(pull09), 0);
        check({tag, "_pull24"}, 32'(pull24), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_sof"}, 32'(sof), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_byte"}, 32'(obyte), 0);
        check({tag, "_chan"}, 32'(chan), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Round robin, single-word bursts, grant latency
        fifo_put(0, 32'hA1B2C3D4);
        fifo_put(0, 32'h55667788);
        fifo_put(1, 32'h11223344);
        expect_word(0, 32'hA1B2C3D4, 1, 4);
        expect_word(1, 32'h11223344, 1, 4);
        expect_word(0, 32'h55667788, 1, 4);
        blen = 4'd0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        check("lat_n_pull09", 32'(pull09), 0);
        check("lat_n_busy", 32'(busy), 0);
        @(negedge clk);
        check("lat_n1_pull09", 32'(pull09), 1);
        check("lat_n1_pull24", 32'(pull24), 0);
        check("lat_n1_busy", 32'(busy), 1);
        check("lat_n1_chan", 32'(chan), 0);
        @(negedge clk);
        check("lat_n2_pull09", 32'(pull09), 0);
        check("lat_n2_valid", 32'(valid), 0);
        @(negedge clk);
        check("lat_n3_valid", 32'(valid), 1);
        check("lat_n3_byte", 32'(obyte), 32'hA1);
        check("lat_n3_sof", 32'(sof), 1);
        wait_drain("rr", 200);

        // Three-word burst from the 2.4 GHz FIFO
        @(posedge clk); #1;
        enable = 1'b0;
        blen = 4'd2;
        clear_counts();
        fifo_put(1, 32'h01234567);
        fifo_put(1, 32'h89ABCDEF);
        fifo_put(1, 32'h0F1E2D3C);
        expect_word(1, 32'h01234567, 1, 4);
        expect_word(1, 32'h89ABCDEF, 0, 4);
        expect_word(1, 32'h0F1E2D3C, 0, 4);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_drain("burst3", 200);
        check("burst3_pulls24", 32'(n_pull24), 3);
        check("burst3_pulls09", 32'(n_pull09), 0);
        check("burst3_bytes", 32'(n_bytes), 12);
        check("burst3_sofs", 32'(n_sof), 1);
        check("burst3_span", 32'(last_cyc - sof_cyc), 15);

        // Backpressure: ready 1,0,0,1
        @(posedge clk); #1;
        enable = 1'b0;
        ready = 1'b0;
        blen = 4'd0;
        clear_counts();
        fifo_put(0, 32'hDEADBEEF);
        expect_word(0, 32'hDEADBEEF, 1, 4);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_valid("bp", 50);
        @(posedge clk); #1;
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            ready = pat[3-i];
            @(posedge clk); #1;
        end
        ready = 1'b1;
        wait_drain("bp", 200);
        check("bp_bytes", 32'(n_bytes), 4);

        // Long burst length, FIFO runs dry after two words
        @(posedge clk); #1;
        enable = 1'b0;
        blen = 4'd7;
        clear_counts();
        fifo_put(0, 32'h01020304);
        fifo_put(0, 32'h05060708);
        expect_word(0, 32'h01020304, 1, 4);
        expect_word(0, 32'h05060708, 0, 4);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_drain("dry", 200);
        repeat (4) @(negedge clk);
        check("dry_bytes", 32'(n_bytes), 8);
        check("dry_pulls09", 32'(n_pull09), 2);
        check("dry_busy", 32'(busy), 0);

        // Enable dropped during byte 1 of word 0
        @(posedge clk); #1;
        enable = 1'b0;
        blen = 4'd3;
        clear_counts();
        fifo_put(0, 32'hF0E1D2C3);
        fifo_put(0, 32'hB4A59687);
        fifo_put(0, 32'h78695A4B);
        fifo_put(0, 32'h3C2D1E0F);
        expect_word(0, 32'hF0E1D2C3, 1, 4);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_valid("endrop", 50);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_drain("endrop", 200);
        repeat (5) @(negedge clk);
        check("endrop_pulls09", 32'(n_pull09), 1);
        check("endrop_bytes", 32'(n_bytes), 4);
        check("endrop_busy", 32'(busy), 0);
        @(posedge clk); #1;
        q09.delete();

        // Reset while presenting byte 2, then both pending -> 09 first
        blen = 4'd0;
        fifo_put(0, 32'h99AABBCC);
        expect_word(0, 32'h99AABBCC, 1, 2);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_valid("rst", 50);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_byte", 32'(obyte), 32'hBB);
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        check_idle("rst_mid");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_more_bytes", 32'(valid), 0);
        check("rst_sb_empty", 32'(exp_q.size()), 0);
        clear_counts();
        fifo_put(0, 32'hCAFEF00D);
        fifo_put(1, 32'h0BADBEEF);
        expect_word(0, 32'hCAFEF00D, 1, 4);
        expect_word(1, 32'h0BADBEEF, 1, 4);
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_pull09", 32'(pull09), 1);
        check("post_rst_pull24", 32'(pull24), 0);
        wait_drain("post_rst", 200);
        check("post_rst_bytes", 32'(n_bytes), 8);

        check("no_pull_on_empty", 32'(bad_pull), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/smi_rx_arbiter.md
SMI_RX_ARBITER -- requirements
Module: smi_rx_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 15, the largest value i_burst_len is permitted to take.
REQ-002 SHALL have port i_sys_clk  input  1  single clock for all logic; one clock, every register on the rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_enable  input  1  when high, new bursts may be granted.
REQ-005 SHALL have port i_burst_len  input  4  words per grant minus 1, sampled at grant.
REQ-006 SHALL have port i_fifo_09_empty  input  1  0.9 GHz FIFO empty flag.
REQ-007 SHALL have port i_fifo_09_pulled_data  input  32  0.9 GHz FIFO word, valid 1 cycle after pull.
REQ-008 SHALL have port o_fifo_09_pull  output  1  one-cycle pull strobe to the 0.9 GHz FIFO.
REQ-009 SHALL have ports i_fifo_24_empty, i_fifo_24_pulled_data, o_fifo_24_pull, identical in width and meaning for the 2.4 GHz FIFO.
REQ-010 SHALL have port o_byte  output  8  serialized byte toward the SMI data path.
REQ-011 SHALL have port o_byte_valid  output  1  o_byte holds a valid byte.
REQ-012 SHALL have port i_byte_ready  input  1  the consumer accepts the byte when valid and ready are both high.
REQ-013 SHALL have port o_channel  output  1  source of the current burst: 0 = 09, 1 = 24.
REQ-014 SHALL have port o_sof  output  1  high with the first byte of each burst.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, PULL, LOAD and SEND, with every output registered.
REQ-017 In IDLE with i_enable=1, SHALL grant a source on these rules:
- both FIFOs non-empty: grant the source not granted last (round-robin);
- one FIFO non-empty: grant that source;
- then latch o_channel, load word_cnt=i_burst_len, go to PULL.
REQ-018 In IDLE with i_enable=0 or both FIFOs empty, SHALL remain in IDLE.
REQ-019 In PULL, SHALL assert the granted pull strobe for exactly one cycle, then go to LOAD; the other pull strobe SHALL stay 0.
REQ-020 In LOAD, SHALL capture the granted FIFO's 32-bit word into a shift register, set byte_idx=0, and go to SEND.
REQ-021 In SEND, SHALL hold o_byte_valid=1 and present bytes MSB first: byte_idx 0..3 → word[31:24], [23:16], [15:8], [7:0].
REQ-022 In SEND, SHALL advance byte_idx only on a cycle where o_byte_valid & i_byte_ready; o_byte SHALL be held stable otherwise.
REQ-023 After the 4th byte is accepted, SHALL go to PULL with word_cnt decremented if all of the following hold; otherwise SHALL go to IDLE:
- word_cnt != 0;
- the granted FIFO is not empty;
- i_enable=1.
REQ-024 Leaving a burst SHALL record the granted source as last-granted.
REQ-025 SHALL assert o_sof only while presenting byte 0 of the first word of a burst.
REQ-026 Latency: FIFO non-empty seen in IDLE at cycle N → pull at N+1 → first o_byte_valid at N+3.
REQ-027 Sustained throughput with ready held high: 4 bytes per 6 cycles.
REQ-028 SHALL hold o_channel constant from grant until return to IDLE.
REQ-029 Deassertion of i_enable mid-burst SHALL NOT truncate the current word; the burst ends at the word boundary.
REQ-030 SHALL sample empty flags only in IDLE and at word boundaries; an empty flag rising mid-word SHALL NOT affect the word in flight.
REQ-031 word_cnt SHALL NOT wrap; a burst transfers at most i_burst_len+1 words.
REQ-032 A change to i_burst_len during a burst SHALL take effect only at the next grant.

Reset
REQ-033 When i_rst=1 at a clock edge, SHALL, regardless of state (including mid-burst):
- go to IDLE;
- clear o_fifo_09_pull, o_fifo_24_pull, o_byte_valid, o_sof, o_busy, o_byte (to 8'h00), o_channel, word_cnt and byte_idx;
- set last-granted=1, so the first grant after reset goes to 09 when both sources are pending.
REQ-034 SHALL discard a partially sent word on reset, with no further byte presented.

Verification
REQ-035 Both FIFOs non-empty, burst_len=0, ready=1, 09 word 32'hA1B2C3D4 → channel 0, bytes A1,B2,C3,D4 with sof on A1; the next grant goes to channel 1.
REQ-036 Only 24 non-empty, burst_len=2, 3 words queued → exactly 3 pulls on o_fifo_24_pull, 12 bytes, single sof, o_fifo_09_pull never high.
REQ-037 Ready toggled 1,0,0,1 during SEND → o_byte held during the ready=0 cycles, no byte lost or duplicated.
REQ-038 burst_len=7 while the FIFO empties after 2 words → burst ends after 8 bytes, back to IDLE, o_busy=0.
REQ-039 Reset asserted while presenting byte 2 → next cycle all outputs 0, IDLE; afterwards, both FIFOs pending → 09 granted first.
REQ-040 i_enable dropped during byte 1 of word 0 with burst_len=3 → bytes 1..3 complete, no further pull, return to IDLE.
